// File: rtl/stopwatch_ctl.sv
// SS.cc stopwatch: run/pause/clear/lap control over a 10 ms prescaler and a mod-10/10/10/6 digit cascade.
// Tick to digits takes 2 edges (tick registered, then applied); all outputs registered; no backpressure.
module stopwatch_ctl #(
   parameter int TICK_DIV = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] d0,
   output logic [3:0] d1,
   output logic [3:0] d2,
   output logic [2:0] d3,
   output logic       running,
   output logic       lap_active,
   output logic       wrap
);
   localparam int TW = $clog2(TICK_DIV);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;

   logic [1:0]    state, state_nx;
   logic [TW-1:0] presc;
   logic          tick, tick_q;
   logic [3:0]    c0, c1, c2;
   logic [2:0]    c3;
   logic [3:0]    c0_nx, c1_nx, c2_nx;
   logic [2:0]    c3_nx;
   logic          cy0, cy1, cy2, cy3;
   logic [3:0]    l0, l1, l2;
   logic [2:0]    l3;
   logic          lap_take, lap_nx, grab;

   always_comb begin
      tick = (state == S_RUN) && (presc == TW'(TICK_DIV - 1));

      // Each digit wraps on >= its limit, so a forced out-of-range value recovers to 0 and carries.
      cy0   = tick_q && (c0 >= 4'd9);
      cy1   = cy0 && (c1 >= 4'd9);
      cy2   = cy1 && (c2 >= 4'd9);
      cy3   = cy2 && (c3 >= 3'd5);
      c0_nx = tick_q ? ((c0 >= 4'd9) ? 4'd0 : c0 + 4'd1) : c0;
      c1_nx = cy0    ? ((c1 >= 4'd9) ? 4'd0 : c1 + 4'd1) : c1;
      c2_nx = cy1    ? ((c2 >= 4'd9) ? 4'd0 : c2 + 4'd1) : c2;
      c3_nx = cy2    ? ((c3 >= 3'd5) ? 3'd0 : c3 + 3'd1) : c3;

      state_nx = state;
      if (start_stop) begin
         case (state)
            S_IDLE:  state_nx = S_RUN;
            S_RUN:   state_nx = S_PAUSE;
            S_PAUSE: state_nx = S_RUN;
            default: state_nx = S_IDLE;
         endcase
      end

      lap_take = lap && !start_stop && (state != S_IDLE);
      lap_nx   = lap_take ? !lap_active : lap_active;
      grab     = lap_take && !lap_active;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;  presc <= '0;  tick_q <= 1'b0;
         c0 <= '0;  c1 <= '0;  c2 <= '0;  c3 <= '0;
         l0 <= '0;  l1 <= '0;  l2 <= '0;  l3 <= '0;
         d0 <= '0;  d1 <= '0;  d2 <= '0;  d3 <= '0;
         running <= 1'b0;  lap_active <= 1'b0;  wrap <= 1'b0;
      end else if (clear) begin
         state <= S_IDLE;  presc <= '0;  tick_q <= 1'b0;
         c0 <= '0;  c1 <= '0;  c2 <= '0;  c3 <= '0;
         d0 <= '0;  d1 <= '0;  d2 <= '0;  d3 <= '0;
         running <= 1'b0;  lap_active <= 1'b0;  wrap <= 1'b0;
      end else begin
         state   <= state_nx;
         running <= (state_nx == S_RUN);
         if (state == S_RUN)
            presc <= tick ? '0 : presc + TW'(1);
         tick_q <= tick;
         c0 <= c0_nx;  c1 <= c1_nx;  c2 <= c2_nx;  c3 <= c3_nx;
         wrap <= cy3;
         lap_active <= lap_nx;
         // The latch captures the pre-increment count even if a tick lands in the same cycle.
         if (grab) begin
            l0 <= c0;  l1 <= c1;  l2 <= c2;  l3 <= c3;
         end
         if (lap_nx) begin
            d0 <= grab ? c0 : l0;
            d1 <= grab ? c1 : l1;
            d2 <= grab ? c2 : l2;
            d3 <= grab ? c3 : l3;
         end else begin
            d0 <= c0_nx;  d1 <= c1_nx;  d2 <= c2_nx;  d3 <= c3_nx;
         end
      end
   end
endmodule

// File: doc/stopwatch_ctl.md
# stopwatch_ctl

Run/pause/clear/lap controller for the four-digit SS.cc stopwatch. Divides the system clock into a 10 ms tick and, while running, advances a cascade of modulo-limited digit counters (hundredths, tenths, seconds-ones, seconds-tens). Drives the display digits with lap-freeze support. Sits between the pre-debounced button pulses and the 7-segment display driver.

## Interface
- TICK_DIV, 1000000: clock cycles per 10 ms tick (100 MHz board). Minimum 2; benches use 4.
- TW, $clog2(TICK_DIV): prescaler width (localparam).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_stop  in  1  single-cycle pulse, already debounced; toggles run/pause.
- clear  in  1  single-cycle pulse; returns to zero/idle.
- lap  in  1  single-cycle pulse; toggles display freeze.
- d0  out  4  displayed hundredths digit, 0..9.
- d1  out  4  displayed tenths digit, 0..9.
- d2  out  4  displayed seconds-ones digit, 0..9.
- d3  out  3  displayed seconds-tens digit, 0..5.
- running  out  1  high in RUN.
- lap_active  out  1  high while the display is frozen.
- wrap  out  1  one-cycle pulse when the count rolls 59.99 -> 00.00.

## Operation
- States: IDLE, RUN, PAUSE. Reset → IDLE.
- IDLE: count = 00.00, prescaler = 0. start_stop → RUN. lap ignored.
- RUN: prescaler counts 0..TICK_DIV-1 and wraps. tick = (prescaler == TICK_DIV-1). start_stop → PAUSE.
- PAUSE: prescaler and count hold. start_stop → RUN, and the prescaler resumes from its held value.
- clear, in any state: → IDLE. Zeroes count and prescaler. lap_active is set to 0.
- Priority in the same cycle: clear > start_stop > lap.
  - lap is ignored in any cycle where start_stop or clear is high.
- Digit cascade on tick:
  - c0 = c0+1 mod 10.
  - c1 increments (mod 10) only when c0 == 9.
  - c2 increments (mod 10) only when c0 == c1 == 9.
  - c3 increments (mod 6) only when c0..c2 are all 9.
  - Each digit uses an independent modulo-L incrementor: L = 10, 10, 10, 6. Each incrementor's carry-out feeds the next digit's carry-in.
- Out-of-range internal digit values (≥ L) are unreachable. If one is forced, that digit goes to 0 on the next tick and carries.
- wrap: asserted on the tick that moves 59.99 → 00.00. The stopwatch stays in RUN.
- Lap:
  - lap in RUN or PAUSE with lap_active = 0: latch the current count into the display register; lap_active = 1.
  - lap with lap_active = 1: release the freeze; lap_active = 0.
  - Counting continues underneath while frozen.
- Display outputs:
  - lap_active = 0: d0..d3 follow the live count.
  - lap_active = 1: d0..d3 show the latched count.

## Timing
- All outputs are registered. Reset values:
  - d0..d3 = 0.
  - running = 0.
  - lap_active = 0.
  - wrap = 0.
- Tick to digits: if tick occurs at cycle n (prescaler == TICK_DIV-1 sampled at edge n), the count and d0..d3 show the new value after edge n+1.
  - wrap is high for exactly that same cycle.
- start_stop sampled at edge n: running changes after edge n.
  - The first tick in RUN comes TICK_DIV cycles after entry from IDLE.
- Tick coincident with start_stop (RUN → PAUSE): the tick is applied. It is the last increment before the hold.
- Tick coincident with clear: clear wins. The count is 00.00 and wrap = 0.
- Tick coincident with lap: the latched value is the pre-increment count.
- Lap press → freeze: d0..d3 are frozen from the edge after lap is sampled. The live count is not disturbed.
- Lap release: d0..d3 show the live count one cycle after the release is sampled.
- rst_n low mid-operation: all state clears immediately (asynchronously). The block restarts in IDLE on the first edge after deassertion.
- Throughput: one increment per TICK_DIV cycles. No backpressure.

## Test plan
- Reset and start (TICK_DIV = 4):
  - Release rst_n → all outputs 0.
  - Pulse start_stop, run 40 cycles → running = 1, display 00.10, no wrap.
- Cascade boundaries:
  - Run to 09.99, one more tick → 10.00.
  - Run to 59.99, one more tick → 00.00, wrap high for exactly 1 cycle, running still 1.
- Pause and resume:
  - Pause at 00.07 with prescaler = 2, idle 50 cycles → count unchanged.
  - Resume → next tick after 2 cycles (prescaler 2→3, then tick), display 00.08.
- Lap:
  - At 00.25 pulse lap → display holds 00.25, lap_active = 1.
  - Run 20 cycles, pulse lap → display shows 00.30, lap_active = 0.
- Simultaneous events:
  - clear with tick at 12.34 → 00.00, IDLE, wrap = 0.
  - start_stop and lap in the same cycle → state toggles, lap_active unchanged.
  - lap with tick at 00.49 → latched value 00.49, live count 00.50.
- Asynchronous reset mid-run: drop rst_n between clock edges at 33.33 with lap_active = 1 → all outputs 0 immediately, IDLE after release.
